// File: rtl/ts_record_replay_ctrl.sv
// rtl/ts_record_replay_ctrl.sv - MPEG-TS passthrough / record / replay controller
//
// Passes a byte-wide TS stream through with one cycle of latency, captures it
// into an internal {sync, data} buffer on REC (optionally starting at the first
// sync byte), and replays the captured entries on PLAY, optionally looped.
//
// Ports:
//   SYS_CLOCK, SYS_RESET        clock, synchronous active-high reset
//   PASS, REC, PLAY             level commands, priority PASS > REC > PLAY
//   TS_VALID_IN/SYNC_IN/DATA_IN input byte stream
//   TS_VALID_OUT/SYNC_OUT/DATA_OUT registered output byte stream
//   STATE                       00 passthrough, 01 record, 10 replay, 11 arm
//   REC_LEN                     number of recorded entries, 0..2**ADDR_WIDTH
//   FULL                        buffer full during/after recording
//   REPLAY_WRAP                 one-cycle pulse with the last entry on the outputs (looped replay)

module ts_record_replay_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter bit ALIGN_SYNC = 1'b1,
  parameter bit LOOP       = 1'b1
) (
  input  logic                  SYS_CLOCK,
  input  logic                  SYS_RESET,
  input  logic                  PASS,
  input  logic                  REC,
  input  logic                  PLAY,
  input  logic                  TS_VALID_IN,
  input  logic                  TS_SYNC_IN,
  input  logic [DATA_WIDTH-1:0] TS_DATA_IN,
  output logic                  TS_VALID_OUT,
  output logic                  TS_SYNC_OUT,
  output logic [DATA_WIDTH-1:0] TS_DATA_OUT,
  output logic [1:0]            STATE,
  output logic [ADDR_WIDTH:0]   REC_LEN,
  output logic                  FULL,
  output logic                  REPLAY_WRAP
);

  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_PASS   = 2'b00,
    ST_RECORD = 2'b01,
    ST_REPLAY = 2'b10,
    ST_ARM    = 2'b11
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  state_t                  w_rec_target;

  logic [DATA_WIDTH:0]     r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_rec_len;
  logic                    r_full;
  logic                    r_rd_vld;
  logic                    r_rd_last;
  logic                    r_rd_sync;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_vout;
  logic                    r_sout;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_wrap;

  logic                    w_len_nz;
  logic                    w_rd_last;
  logic                    w_enter_rec;
  logic                    w_leave;
  logic                    w_issue;
  logic                    w_wr_en;

  always_comb begin
    w_rec_target = ALIGN_SYNC ? ST_ARM : ST_RECORD;
    w_len_nz     = (r_rec_len != '0);
    // Read pointer is issuing the final recorded entry this cycle.
    w_rd_last    = ({1'b0, r_rd_ptr} == (r_rec_len - LEN_ONE));

    w_next = r_state;
    case (r_state)
      ST_PASS: begin
        if (PASS)                  w_next = ST_PASS;
        else if (REC)              w_next = w_rec_target;
        else if (PLAY && w_len_nz) w_next = ST_REPLAY;
      end
      ST_ARM: begin
        if (PASS)                            w_next = ST_PASS;
        else if (TS_VALID_IN && TS_SYNC_IN)  w_next = ST_RECORD;
      end
      ST_RECORD: begin
        if (PASS) w_next = ST_PASS;
      end
      ST_REPLAY: begin
        if (PASS)                  w_next = ST_PASS;
        else if (REC)              w_next = w_rec_target;
        else if (w_rd_last && !LOOP) w_next = ST_PASS;
      end
      default: w_next = ST_PASS;
    endcase

    // A fresh recording (or arming) wipes length, full flag and write pointer.
    w_enter_rec = ((r_state == ST_PASS) || (r_state == ST_REPLAY)) &&
                  ((w_next == ST_ARM) || (w_next == ST_RECORD));
    // Replay interrupted by a command: drop the pending read and show input.
    w_leave     = (r_state == ST_REPLAY) && (PASS || REC);
    w_issue     = (r_state == ST_REPLAY) && !w_leave;
    // The sync byte that releases ARM is itself entry 0.
    w_wr_en     = ((r_state == ST_ARM) && (w_next == ST_RECORD)) ||
                  ((r_state == ST_RECORD) && !PASS && TS_VALID_IN && !r_full);
  end

  // Buffer storage and synchronous read port; contents survive reset.
  always_ff @(posedge SYS_CLOCK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {TS_SYNC_IN, TS_DATA_IN};
    if (w_issue) {r_rd_sync, r_rd_data} <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      r_state   <= ST_PASS;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rec_len <= '0;
      r_full    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
      r_vout    <= 1'b0;
      r_sout    <= 1'b0;
      r_dout    <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_enter_rec) begin
        r_wr_ptr  <= '0;
        r_rec_len <= '0;
        r_full    <= 1'b0;
      end else if (w_wr_en) begin
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
        r_rec_len <= r_rec_len + LEN_ONE;
        r_full    <= ((r_rec_len + LEN_ONE) == LEN_MAX);
      end

      if (r_state != ST_REPLAY)  r_rd_ptr <= '0;
      else if (w_issue)          r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + PTR_ONE;

      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue && w_rd_last;

      // A read already in flight is still emitted after a non-looped replay
      // has returned to passthrough, so the last entry is never lost.
      if (r_rd_vld && !w_leave) begin
        r_vout <= 1'b1;
        r_sout <= r_rd_sync;
        r_dout <= r_rd_data;
        r_wrap <= r_rd_last && LOOP;
      end else if (w_issue) begin
        r_vout <= 1'b0;
        r_sout <= 1'b0;
        r_dout <= '0;
        r_wrap <= 1'b0;
      end else begin
        r_vout <= TS_VALID_IN;
        r_sout <= TS_SYNC_IN;
        r_dout <= TS_DATA_IN;
        r_wrap <= 1'b0;
      end
    end
  end

  assign TS_VALID_OUT = r_vout;
  assign TS_SYNC_OUT  = r_sout;
  assign TS_DATA_OUT  = r_dout;
  assign STATE        = r_state;
  assign REC_LEN      = r_rec_len;
  assign FULL         = r_full;
  assign REPLAY_WRAP  = r_wrap;

endmodule
